mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: memory address width.
REQ-002 SHALL have parameter DATA_W, default 8: memory data width.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports a_req, b_req, input, 1 each: access request.
REQ-006 SHALL have ports a_we, b_we, input, 1 each: 1 = write, 0 = read.
REQ-007 SHALL have ports a_adr, b_adr, input, ADDR_W each: access address.
REQ-008 SHALL have ports a_dat_w, b_dat_w, input, DATA_W each: write data.
REQ-009 SHALL have ports a_ack, b_ack, output, 1 each: single-cycle completion pulse.
REQ-010 SHALL have ports a_dat_r, b_dat_r, output, DATA_W each: registered read data.
REQ-011 SHALL have ports mem_adr (ADDR_W), mem_dat_w (DATA_W), mem_we (1), output: memory port drive.
REQ-012 SHALL have port mem_dat_r, input, DATA_W: memory read data, valid one cycle after mem_adr is presented.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> IDLE, one cycle per state, no other transitions.
REQ-015 In IDLE with at least one eligible request, SHALL latch grant (A or B) and go to ISSUE; with none, SHALL remain in IDLE.
REQ-016 A port SHALL be ineligible in the cycle its ack is high; its req is ignored that cycle.
REQ-017 In ISSUE, SHALL drive mem_adr, mem_dat_w and mem_we from the granted port's inputs; requesters hold adr/we/dat_w stable from req until ack.
REQ-018 Outside ISSUE, mem_we SHALL be 0, mem_adr 0, mem_dat_w 0.
REQ-019 In CAPTURE, for a read, SHALL load mem_dat_r into the granted port's dat_r register at the clock edge ending CAPTURE.
REQ-020 Writes SHALL leave both dat_r registers unchanged.
REQ-021 The non-granted port's dat_r SHALL never change.
REQ-022 ack of the granted port SHALL be registered, high for exactly the cycle after CAPTURE; latency SHALL be req sampled in IDLE at cycle T -> ack high at T+3, for both reads and writes.
REQ-023 dat_r SHALL be valid when ack is high and SHALL hold until that port's next read completes.
REQ-024 Back-to-back accesses: the cycle after CAPTURE is IDLE and SHALL accept the other port's pending request, or the same port's new request in the following cycle; peak throughput is one access per 3 cycles with alternation, per 4 for a single port.
REQ-025 Simultaneous a_req and b_req in IDLE SHALL be resolved per REQ-030/031.
REQ-026 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the access.

Reset
REQ-027 On rst high, immediately and asynchronously: state=IDLE, a_ack=b_ack=0, a_dat_r=b_dat_r=0, mem_we=0, mem_adr=0, mem_dat_w=0, busy=0, last-served pointer=B.
REQ-028 Reset during ISSUE SHALL suppress the write (mem_we deasserted before the edge); reset during CAPTURE SHALL discard read data and produce no ack.
REQ-029 After rst deasserts, first eligible request SHALL be sampled on the next rising edge.

Configuration
REQ-030 With macro MEM_ARB_ROUND_ROBIN_EN defined: on a tie, SHALL grant the port not last served; the pointer updates on each grant; after reset A wins the first tie.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, A SHALL always win ties; no pointer register exists.

Verification
REQ-032 Memory preloaded with mem[3]=8'hFE; A read adr 3 at T -> a_ack high at T+3, a_dat_r=8'hFE, b_dat_r unchanged=8'h00.
REQ-033 B write adr 5 data 8'h3C at T, then B read adr 5 -> b_dat_r=8'h3C at second ack; mem_we high exactly one cycle.
REQ-034 a_req=b_req=1 held for 4 accesses: with MEM_ARB_ROUND_ROBIN_EN acks order A,B,A,B; without, A,A,A,A while B starves.
REQ-035 rst asserted in ISSUE of A write 8'h77 to adr 2 -> mem[2] unchanged, no a_ack, all outputs 0 immediately.
REQ-036 A holds req high through ack -> exactly one ack per 4 cycles, no duplicate access in the ack cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-memory arbiter, IDLE/ISSUE/CAPTURE access FSM
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port A.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] a_dat_w,
    input  logic [DATA_W-1:0] b_dat_w,
    output logic              a_ack,
    output logic              b_ack,
    output logic [DATA_W-1:0] a_dat_r,
    output logic [DATA_W-1:0] b_dat_r,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_w,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dat_r,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              state_q;
    logic                grant_q;       // 0 = port A, 1 = port B
    logic                we_q;
    logic                a_ack_q;
    logic                b_ack_q;
    logic [DATA_W-1:0]   a_dat_r_q;
    logic [DATA_W-1:0]   b_dat_r_q;
    logic                a_elig;
    logic                b_elig;
    logic                grant_d;
    logic                issue;

    // A port whose ack is showing this cycle must not be re-granted on the same edge.
    assign a_elig = a_req & ~a_ack_q;
    assign b_elig = b_req & ~b_ack_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;                       // port served by the most recent grant
    assign grant_d = b_elig & (~a_elig | ~last_q);
`else
    assign grant_d = b_elig & ~a_elig;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            we_q      <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_dat_r_q <= '0;
            b_dat_r_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (a_elig | b_elig) begin
                        grant_q <= grant_d;
                        we_q    <= grant_d ? b_we : a_we;
                        state_q <= S_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_q  <= grant_d;
`endif
                    end
                end
                S_ISSUE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_q <= S_IDLE;
                    a_ack_q <= ~grant_q;
                    b_ack_q <= grant_q;
                    if (!we_q) begin
                        if (grant_q) begin
                            b_dat_r_q <= mem_dat_r;
                        end else begin
                            a_dat_r_q <= mem_dat_r;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory drive is a decode of the state register, so an async reset drops mem_we at once.
    assign issue     = (state_q == S_ISSUE);
    assign mem_we    = issue & we_q;
    assign mem_adr   = issue ? (grant_q ? b_adr : a_adr) : '0;
    assign mem_dat_w = issue ? (grant_q ? b_dat_w : a_dat_w) : '0;

    assign busy    = (state_q != S_IDLE);
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_dat_r = a_dat_r_q;
    assign b_dat_r = b_dat_r_q;

endmodule
